// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, fault causes,
// access sizes and FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational access decode: misalign/unsupported check, byte enables and
// store lane shift on the request side; lane extract and extension on the load side.
module lsu_align
   import lsu_pkg::*;
#(
   parameter  int XLEN  = 32,
   localparam int NB    = XLEN / 8,
   localparam int OFF_W = $clog2(NB)
) (
   input  logic [2:0]       funct3,
   input  logic [OFF_W-1:0] off,
   input  logic [XLEN-1:0]  store_data,
   output logic             bad,
   output logic [NB-1:0]    be,
   output logic [XLEN-1:0]  wdata,
   input  logic [1:0]       ld_size,
   input  logic             ld_uns,
   input  logic [OFF_W-1:0] ld_off,
   input  logic [XLEN-1:0]  rdata,
   output logic [XLEN-1:0]  ld_data
);

   logic            unsup;
   logic            mis;
   logic [NB-1:0]   size_mask;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] keep;
   logic [6:0]      nbits;
   logic            sign;

   always_comb begin
      // 111 never exists; doubleword and LWU only exist on a 64-bit datapath
      unsup = (funct3 == 3'b111) ||
              ((XLEN == 32) && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
      mis       = 1'b0;
      size_mask = '1;
      case (size_e'(funct3[1:0]))
         SZ_B: begin mis = 1'b0;        size_mask = NB'(1);  end
         SZ_H: begin mis = off[0];      size_mask = NB'(3);  end
         SZ_W: begin mis = |off[1:0];   size_mask = NB'(15); end
         default: begin mis = |off;     size_mask = '1;      end
      endcase
      bad   = unsup | mis;
      be    = size_mask << off;
      wdata = store_data << {off, 3'b000};
   end

   always_comb begin
      shifted = rdata >> {ld_off, 3'b000};
      nbits   = 7'd8 << ld_size;
      keep    = ~({XLEN{1'b1}} << nbits);
      case (size_e'(ld_size))
         SZ_B:    sign = shifted[7];
         SZ_H:    sign = shifted[15];
         SZ_W:    sign = shifted[31];
         default: sign = shifted[XLEN-1];
      endcase
      ld_data = (shifted & keep) | ((sign & ~ld_uns) ? ~keep : '0);
   end

endmodule

// File: rtl/lsu_mem.sv
// Memory-stage load/store unit: two-state request FSM with registered memory
// interface, load writeback, misalign rejection and memory time-out.
module lsu_mem
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                store,
   input  logic [2:0]          funct3,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [XLEN-1:0]     store_data,
   input  logic [4:0]          rd_in,
   output logic                busy,
   output logic                mem_req,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN/8-1:0]   mem_be,
   output logic [XLEN-1:0]     mem_wdata,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_ready,
   output logic [4:0]          rd,
   output logic [XLEN-1:0]     rd_data,
   output logic                rd_we,
   output logic                fault,
   output logic [1:0]          fault_cause
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [OFF_W-1:0] off_q;

   logic             bad;
   logic [NB-1:0]    be;
   logic [XLEN-1:0]  wdata;
   logic [XLEN-1:0]  ld_data;
   logic             timed_out;

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (funct3),
      .off        (addr[OFF_W-1:0]),
      .store_data (store_data),
      .bad        (bad),
      .be         (be),
      .wdata      (wdata),
      .ld_size    (size_q),
      .ld_uns     (uns_q),
      .ld_off     (off_q),
      .rdata      (mem_rdata),
      .ld_data    (ld_data)
   );

   // cnt counts finished WAIT cycles, so the TIMEOUT-th idle cycle sees CNT_LAST
   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         off_q       <= '0;
         busy        <= 1'b0;
         mem_req     <= 1'b0;
         mem_wen     <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= '0;
         mem_wdata   <= '0;
         rd          <= '0;
         rd_data     <= '0;
         rd_we       <= 1'b0;
         fault       <= 1'b0;
         fault_cause <= '0;
      end else begin
         rd_we <= 1'b0;
         fault <= 1'b0;
         case (state)
            S_IDLE: begin
               if (store || load) begin
                  if (bad) begin
                     fault       <= 1'b1;
                     fault_cause <= CAUSE_MISALIGN;
                  end else begin
                     mem_req   <= 1'b1;
                     busy      <= 1'b1;
                     mem_wen   <= store;
                     mem_addr  <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     mem_be    <= be;
                     mem_wdata <= wdata;
                     rd        <= rd_in;
                     size_q    <= funct3[1:0];
                     uns_q     <= funct3[2];
                     off_q     <= addr[OFF_W-1:0];
                     cnt       <= '0;
                     state     <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
                  if (!mem_wen) begin
                     rd_data <= ld_data;
                     rd_we   <= (rd != 5'd0);
                  end
               end else if (timed_out) begin
                  mem_req     <= 1'b0;
                  busy        <= 1'b0;
                  fault       <= 1'b1;
                  fault_cause <= CAUSE_TIMEOUT;
                  state       <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
